// File: rtl/gray2bin_arbiter_pkg.sv
// Shared utilities for Gray-coded pointer handling.
package gray2bin_arbiter_pkg;

  // Widest Gray word the helpers accept; narrower words are zero-extended,
  // which does not change their binary value.
  localparam int GRAY_MAX_W = 64;

  // Binary bit 'pos' of a Gray word is the XOR of all Gray bits at or above 'pos'.
  function automatic logic gray_to_bin_bit(input logic [GRAY_MAX_W-1:0] gray,
                                           input int unsigned pos);
    return ^(gray >> pos);
  endfunction

endpackage

// File: rtl/gray2bin_arbiter_conv.sv
// Purely combinational Gray-to-binary converter of width DW.
module gray2bin_arbiter_conv
  import gray2bin_arbiter_pkg::*;
#(
  parameter int DW = 4
) (
  input  logic [DW-1:0] gray_i,
  output logic [DW-1:0] bin_o
);

  logic [GRAY_MAX_W-1:0] gray_ext;

  // Zero-extend the word to the helper width.
  always_comb begin
    gray_ext           = '0;
    gray_ext[DW-1:0]   = gray_i;
  end

  for (genvar gi = 0; gi < DW; gi++) begin : g_bit
    assign bin_o[gi] = gray_to_bin_bit(gray_ext, gi);
  end

endmodule

// File: rtl/gray2bin_arbiter.sv
// Round-robin arbiter sharing one Gray-to-binary converter among NREQ
// requesters, with a single registered result stage.
module gray2bin_arbiter
  import gray2bin_arbiter_pkg::*;
#(
  parameter int  DW   = 4,
  parameter int  NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*DW-1:0] req_gray,
  output logic [NREQ-1:0]    req_ready,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DW-1:0]      out_bin,
  output logic [IDW-1:0]     out_id
);

  logic           out_valid_q, out_valid_d;
  logic [DW-1:0]  out_bin_q, out_bin_d;
  logic [IDW-1:0] out_id_q, out_id_d;
  logic [IDW-1:0] last_grant_q, last_grant_d;

  logic           can_accept;
  logic           grant_found;
  logic [IDW-1:0] grant_idx;
  logic [DW-1:0]  grant_gray;
  logic [DW-1:0]  grant_bin;

  // The result slot is free when empty or being drained this cycle.
  assign can_accept = !out_valid_q || out_ready;

  // Cyclic search starting just after the last winner; no grant while reset
  // is asserted so nothing is accepted that would then be discarded.
  always_comb begin : rr_search
    int cand;
    cand        = 0;
    grant_found = 1'b0;
    grant_idx   = '0;
    if (can_accept && rst_n) begin
      for (int o = 1; o <= NREQ; o++) begin
        cand = (int'(last_grant_q) + o) % NREQ;
        if (!grant_found && req_valid[IDW'(cand)]) begin
          grant_found = 1'b1;
          grant_idx   = IDW'(cand);
        end
      end
    end
  end

  // One-hot accept strobe for the winner.
  always_comb begin
    req_ready = '0;
    if (grant_found) req_ready[grant_idx] = 1'b1;
  end

  assign grant_gray = req_gray[int'(grant_idx)*DW +: DW];

  gray2bin_arbiter_conv #(
    .DW(DW)
  ) u_conv (
    .gray_i(grant_gray),
    .bin_o (grant_bin)
  );

  // Load a new result on grant, otherwise drain or hold.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_bin_d    = out_bin_q;
    out_id_d     = out_id_q;
    last_grant_d = last_grant_q;
    if (grant_found) begin
      out_valid_d  = 1'b1;
      out_bin_d    = grant_bin;
      out_id_d     = grant_idx;
      last_grant_d = grant_idx;
    end else if (out_ready) begin
      out_valid_d  = 1'b0;
    end
  end

  // Result register and round-robin pointer; pointer resets so requester 0 wins first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_bin_q    <= '0;
      out_id_q     <= '0;
      last_grant_q <= IDW'(NREQ - 1);
    end else begin
      out_valid_q  <= out_valid_d;
      out_bin_q    <= out_bin_d;
      out_id_q     <= out_id_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_bin   = out_bin_q;
  assign out_id    = out_id_q;

endmodule

// File: tb/tb_gray2bin_arbiter.sv
// Self-checking bench for gray2bin_arbiter (DW=4, NREQ=4) with a result scoreboard.
module tb_gray2bin_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [15:0] req_gray;
  logic [3:0]  req_ready;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_bin;
  logic [1:0]  out_id;

  typedef struct packed {
    logic [1:0] id;
    logic [3:0] bin;
  } res_t;

  res_t       sb[$];
  logic [1:0] m_last;
  logic [3:0] exp_rdy;
  int         checks = 0;
  int         errors = 0;

  gray2bin_arbiter #(.DW(4), .NREQ(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_gray (req_gray),
    .req_ready(req_ready),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_bin  (out_bin),
    .out_id   (out_id)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] ref_bin(input logic [3:0] g);
    logic [3:0] b;
    for (int i = 0; i < 4; i++) b[i] = ^(g >> i);
    return b;
  endfunction

  function automatic logic [3:0] gray_of(input int n);
    logic [3:0] v;
    v = 4'(n);
    return v ^ (v >> 1);
  endfunction

  function automatic logic [3:0] rr_pick(input logic [1:0] last, input logic [3:0] valid);
    logic [3:0] r;
    int k;
    r = 4'b0000;
    for (int o = 1; o <= 4; o++) begin
      k = (int'(last) + o) % 4;
      if (r == 4'b0000 && valid[k]) r[k] = 1'b1;
    end
    return r;
  endfunction

  function automatic logic [1:0] oh2idx(input logic [3:0] oh);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 0; i < 4; i++) if (oh[i]) r = 2'(i);
    return r;
  endfunction

  // Scoreboard bookkeeping for the cycle just checked: retire a drained
  // result, enqueue the result of the expected grant.
  task automatic sb_update();
    res_t e;
    if (sb.size() != 0 && out_ready) begin
      e = sb.pop_front();
      $display("txn: id=%0d bin=%b", e.id, e.bin);
    end
    if (exp_rdy != 4'b0000) begin
      e.id  = oh2idx(exp_rdy);
      e.bin = ref_bin(req_gray[int'(e.id)*4 +: 4]);
      sb.push_back(e);
      m_last = e.id;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      req_valid = 4'($urandom);
      req_gray  = 16'($urandom);
      out_ready = 1'($urandom);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || out_bin !== 4'd0 || out_id !== 2'd0 || req_ready !== 4'b0000) begin
        errors++;
        $display("FAIL reset_state: valid=%b bin=%b id=%0d ready=%b, expected 0 0000 0 0000",
                 out_valid, out_bin, out_id, req_ready);
      end
    end
    sb.delete();
    m_last = 2'd3;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin
        rst_n = 1'b1; req_valid = 4'b1111; req_gray = 16'h8C3A; out_ready = 1'b1;
      end else begin
        req_valid = req_valid & ~exp_rdy;
      end
      @(negedge clk);
      exp_rdy = (sb.size() == 0 || out_ready) ? rr_pick(m_last, req_valid) : 4'b0000;
      if (c == 0) begin
        checks++;
        if (req_ready !== 4'b0001) begin
          errors++; $display("FAIL reset_first_grant: req_ready=%b expected 0001", req_ready);
        end
      end
      checks++;
      if (req_ready !== exp_rdy) begin
        errors++; $display("FAIL reset_ready: req_ready=%b expected %b", req_ready, exp_rdy);
      end
      checks++;
      if (out_valid !== (sb.size() != 0)) begin
        errors++; $display("FAIL reset_valid: out_valid=%b expected %b", out_valid, sb.size() != 0);
      end
      if (sb.size() != 0) begin
        checks++;
        if ({out_id, out_bin} !== {sb[0].id, sb[0].bin}) begin
          errors++; $display("FAIL reset_result: id=%0d bin=%b expected id=%0d bin=%b",
                             out_id, out_bin, sb[0].id, sb[0].bin);
        end
      end
      sb_update();
    end
  endtask

  task automatic test_fairness();
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin
        req_valid = 4'b1111; req_gray = 16'h5E27; out_ready = 1'b1;
      end else if (c == 6) begin
        req_valid = 4'b1100;
      end else if (c > 6) begin
        req_valid = req_valid & ~exp_rdy;
      end
      @(negedge clk);
      exp_rdy = (sb.size() == 0 || out_ready) ? rr_pick(m_last, req_valid) : 4'b0000;
      if (c >= 1 && c <= 6) begin
        checks++;
        if (out_valid !== 1'b1 || out_id !== 2'((c - 1) % 4)) begin
          errors++; $display("FAIL fair_order: valid=%b id=%0d expected valid=1 id=%0d",
                             out_valid, out_id, (c - 1) % 4);
        end
      end
      checks++;
      if (req_ready !== exp_rdy) begin
        errors++; $display("FAIL fair_ready: req_ready=%b expected %b", req_ready, exp_rdy);
      end
      checks++;
      if (out_valid !== (sb.size() != 0)) begin
        errors++; $display("FAIL fair_valid: out_valid=%b expected %b", out_valid, sb.size() != 0);
      end
      if (sb.size() != 0) begin
        checks++;
        if ({out_id, out_bin} !== {sb[0].id, sb[0].bin}) begin
          errors++; $display("FAIL fair_result: id=%0d bin=%b expected id=%0d bin=%b",
                             out_id, out_bin, sb[0].id, sb[0].bin);
        end
      end
      sb_update();
    end
  endtask

  task automatic test_single();
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin
        req_valid = 4'b0100; req_gray = 16'h0D00; out_ready = 1'b1;
      end else begin
        req_valid = req_valid & ~exp_rdy;
      end
      @(negedge clk);
      exp_rdy = (sb.size() == 0 || out_ready) ? rr_pick(m_last, req_valid) : 4'b0000;
      if (c == 0) begin
        checks++;
        if (req_ready !== 4'b0100) begin
          errors++; $display("FAIL single_ready: req_ready=%b expected 0100", req_ready);
        end
      end
      if (c == 1) begin
        checks++;
        if (out_valid !== 1'b1 || out_bin !== 4'b1001 || out_id !== 2'd2) begin
          errors++; $display("FAIL single_result: valid=%b bin=%b id=%0d expected 1 1001 2",
                             out_valid, out_bin, out_id);
        end
      end
      checks++;
      if (out_valid !== (sb.size() != 0)) begin
        errors++; $display("FAIL single_valid: out_valid=%b expected %b", out_valid, sb.size() != 0);
      end
      sb_update();
    end
  endtask

  task automatic test_backpressure();
    logic [3:0] hold_bin;
    hold_bin = ref_bin(4'b0110);
    for (int c = 0; c < 9; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin
        req_valid = 4'b0010; req_gray = 16'h9A61; out_ready = 1'b1;
      end else if (c == 1) begin
        req_valid = 4'b1110; out_ready = 1'b0;
      end else if (c == 4) begin
        out_ready = 1'b1;
      end else if (c >= 5) begin
        req_valid = req_valid & ~exp_rdy;
      end
      @(negedge clk);
      exp_rdy = (sb.size() == 0 || out_ready) ? rr_pick(m_last, req_valid) : 4'b0000;
      if (c >= 1 && c <= 4) begin
        checks++;
        if (out_valid !== 1'b1 || out_id !== 2'd1 || out_bin !== hold_bin) begin
          errors++; $display("FAIL bp_hold: valid=%b id=%0d bin=%b expected 1 1 %b",
                             out_valid, out_id, out_bin, hold_bin);
        end
      end
      if (c >= 1 && c <= 3) begin
        checks++;
        if (req_ready !== 4'b0000) begin
          errors++; $display("FAIL bp_stall_ready: req_ready=%b expected 0000", req_ready);
        end
      end
      if (c == 4) begin
        checks++;
        if (req_ready !== 4'b0100) begin
          errors++; $display("FAIL bp_release_grant: req_ready=%b expected 0100", req_ready);
        end
      end
      if (c == 5) begin
        checks++;
        if (out_valid !== 1'b1 || out_id !== 2'd2) begin
          errors++; $display("FAIL bp_next_result: valid=%b id=%0d expected 1 2", out_valid, out_id);
        end
      end
      checks++;
      if (req_ready !== exp_rdy) begin
        errors++; $display("FAIL bp_ready: req_ready=%b expected %b", req_ready, exp_rdy);
      end
      if (sb.size() != 0) begin
        checks++;
        if ({out_id, out_bin} !== {sb[0].id, sb[0].bin}) begin
          errors++; $display("FAIL bp_result: id=%0d bin=%b expected id=%0d bin=%b",
                             out_id, out_bin, sb[0].id, sb[0].bin);
        end
      end
      sb_update();
    end
  endtask

  task automatic test_mid_reset();
    @(posedge clk); #1;
    req_valid = 4'b0001; req_gray = 16'h47B3; out_ready = 1'b1;
    @(negedge clk);
    exp_rdy = rr_pick(m_last, req_valid);
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++; $display("FAIL mid_pre_grant: req_ready=%b expected 0001", req_ready);
    end
    sb_update();
    @(posedge clk); #1;
    req_valid = 4'b0000; out_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_id !== 2'd0) begin
      errors++; $display("FAIL mid_pre_valid: valid=%b id=%0d expected 1 0", out_valid, out_id);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL mid_async_drop: out_valid=%b expected 0", out_valid);
    end
    sb.delete();
    m_last = 2'd3;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin
        rst_n = 1'b1; req_valid = 4'b1010; req_gray = 16'hC1E5; out_ready = 1'b1;
      end else begin
        req_valid = req_valid & ~exp_rdy;
      end
      @(negedge clk);
      exp_rdy = (sb.size() == 0 || out_ready) ? rr_pick(m_last, req_valid) : 4'b0000;
      if (c == 0) begin
        checks++;
        if (req_ready !== 4'b0010) begin
          errors++; $display("FAIL mid_first_grant: req_ready=%b expected 0010", req_ready);
        end
      end
      if (c == 1) begin
        checks++;
        if (out_valid !== 1'b1 || out_id !== 2'd1) begin
          errors++; $display("FAIL mid_first_id: valid=%b id=%0d expected 1 1", out_valid, out_id);
        end
      end
      checks++;
      if (req_ready !== exp_rdy) begin
        errors++; $display("FAIL mid_ready: req_ready=%b expected %b", req_ready, exp_rdy);
      end
      if (sb.size() != 0) begin
        checks++;
        if ({out_id, out_bin} !== {sb[0].id, sb[0].bin}) begin
          errors++; $display("FAIL mid_result: id=%0d bin=%b expected id=%0d bin=%b",
                             out_id, out_bin, sb[0].id, sb[0].bin);
        end
      end
      sb_update();
    end
  endtask

  task automatic test_sweep();
    for (int c = 0; c <= 17; c++) begin
      @(posedge clk); #1;
      out_ready = 1'b1;
      if (c < 16) begin
        req_valid = 4'b1000;
        req_gray  = {gray_of(c), 12'h5A5};
      end else begin
        req_valid = 4'b0000;
      end
      @(negedge clk);
      exp_rdy = (sb.size() == 0 || out_ready) ? rr_pick(m_last, req_valid) : 4'b0000;
      if (c >= 1 && c <= 16) begin
        checks++;
        if (out_valid !== 1'b1 || out_bin !== 4'(c - 1) || out_id !== 2'd3) begin
          errors++; $display("FAIL sweep_conv: valid=%b bin=%0d id=%0d expected 1 %0d 3",
                             out_valid, out_bin, out_id, c - 1);
        end
      end
      checks++;
      if (req_ready !== exp_rdy) begin
        errors++; $display("FAIL sweep_ready: req_ready=%b expected %b", req_ready, exp_rdy);
      end
      checks++;
      if (out_valid !== (sb.size() != 0)) begin
        errors++; $display("FAIL sweep_valid: out_valid=%b expected %b", out_valid, sb.size() != 0);
      end
      sb_update();
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 4'b0000;
    req_gray  = 16'h0000;
    out_ready = 1'b0;
    exp_rdy   = 4'b0000;
    m_last    = 2'd3;
    test_reset();
    test_fairness();
    test_single();
    test_backpressure();
    test_mid_reset();
    test_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
